// File: rtl/sp_ctrl_pkg.sv
// Shared types and constants for the stack-pointer controller.
package sp_ctrl_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_ADJ  = 2'b10,
        OP_NOP  = 2'b11
    } core_op_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE
    } state_e;

    // A one-word frame still needs a 1-bit index field.
    function automatic int idx_width(input int ctx_words);
        return (ctx_words > 1) ? $clog2(ctx_words) : 1;
    endfunction

endpackage

// File: rtl/sp_ctrl_if.sv
// Request/response and stack-memory signals between decode/trap logic, memory and sp_ctrl.
interface sp_ctrl_if
    import sp_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CTX_WORDS = 4
);
    localparam int IDX_W = idx_width(CTX_WORDS);

    logic             core_req;
    logic [1:0]       core_op;
    logic [WIDTH-1:0] core_imm;
    logic             core_gnt;
    logic             core_err;
    logic             trap_req;
    logic             trap_ret;
    logic             trap_ack;
    logic             trap_done;
    logic             trap_err;
    logic             mem_we;
    logic             mem_re;
    logic [WIDTH-1:0] mem_addr;
    logic [IDX_W-1:0] mem_idx;
    logic             mem_rdy;

    modport master (
        output core_req, core_op, core_imm, trap_req, trap_ret, mem_rdy,
        input  core_gnt, core_err, trap_ack, trap_done, trap_err,
               mem_we, mem_re, mem_addr, mem_idx
    );

    modport slave (
        input  core_req, core_op, core_imm, trap_req, trap_ret, mem_rdy,
        output core_gnt, core_err, trap_ack, trap_done, trap_err,
               mem_we, mem_re, mem_addr, mem_idx
    );

endinterface

// File: rtl/sp_bound_chk.sv
// Combinational stack range check; candidate carries one extra bit so wrap-around lands out of range.
module sp_bound_chk #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   cand,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] base,
    output logic             in_range
);

    assign in_range = (cand >= {1'b0, limit}) && (cand <= {1'b0, base});

endmodule

// File: rtl/sp_ctrl.sv
// Stack-pointer controller: core push/pop/adjust and trap context save/restore bursts.
// Bounds checking is built only when SP_BOUNDS_CHECK_EN is defined.
//
// state   | meaning
// INIT    | load STACK_BASE into SP, one cycle
// IDLE    | arbitrate trap_ret > trap_req > core_req
// SAVE    | push CTX_WORDS context words, idx 0..N-1
// RESTORE | pop CTX_WORDS context words, idx N-1..0
module sp_ctrl
    import sp_ctrl_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] STACK_BASE  = WIDTH'(32'h0000_1000),
    parameter logic [WIDTH-1:0] STACK_LIMIT = WIDTH'(32'h0000_0800),
    parameter int               CTX_WORDS   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] sp_q,
    output logic             sp_en,
    output logic [WIDTH-1:0] sp_in,
    sp_ctrl_if.slave         bus
);

    localparam int               IDX_W     = idx_width(CTX_WORDS);
    localparam logic [WIDTH-1:0] STEP      = WIDTH'(WORD_BYTES);
    localparam logic [WIDTH-1:0] FRAME     = WIDTH'(WORD_BYTES * CTX_WORDS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(CTX_WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] left_q, left_d;
    core_op_e         op;
    logic [WIDTH-1:0] imm_al;
    logic [WIDTH-1:0] core_next;
    logic             core_ok;
    logic             frame_ok;
    logic             unused_imm;

    assign op         = core_op_e'(bus.core_op);
    assign imm_al     = {bus.core_imm[WIDTH-1:2], 2'b00};
    assign unused_imm = ^bus.core_imm[1:0];

    always_comb begin
        core_next = sp_q;
        case (op)
            OP_PUSH: core_next = sp_q - STEP;
            OP_POP:  core_next = sp_q + STEP;
            OP_ADJ:  core_next = sp_q + imm_al;
            default: core_next = sp_q;
        endcase
    end

`ifdef SP_BOUNDS_CHECK_EN
    logic [WIDTH:0] core_cand;
    logic [WIDTH:0] frame_cand;

    // Signed adjust is sign-extended into the extra bit so underflow shows as a huge value.
    always_comb begin
        core_cand = {1'b0, sp_q};
        case (op)
            OP_PUSH: core_cand = {1'b0, sp_q} - {1'b0, STEP};
            OP_POP:  core_cand = {1'b0, sp_q} + {1'b0, STEP};
            OP_ADJ:  core_cand = {1'b0, sp_q} + {imm_al[WIDTH-1], imm_al};
            default: core_cand = {1'b0, sp_q};
        endcase
    end

    assign frame_cand = bus.trap_ret ? ({1'b0, sp_q} + {1'b0, FRAME})
                                     : ({1'b0, sp_q} - {1'b0, FRAME});

    sp_bound_chk #(.WIDTH(WIDTH)) u_chk_core (
        .cand     (core_cand),
        .limit    (STACK_LIMIT),
        .base     (STACK_BASE),
        .in_range (core_ok)
    );

    sp_bound_chk #(.WIDTH(WIDTH)) u_chk_frame (
        .cand     (frame_cand),
        .limit    (STACK_LIMIT),
        .base     (STACK_BASE),
        .in_range (frame_ok)
    );
`else
    assign core_ok  = 1'b1;
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_INIT;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        left_d        = left_q;
        sp_en         = 1'b0;
        sp_in         = '0;
        bus.core_gnt  = 1'b0;
        bus.core_err  = 1'b0;
        bus.trap_ack  = 1'b0;
        bus.trap_done = 1'b0;
        bus.trap_err  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_idx   = '0;

        case (state_q)
            ST_INIT: begin
                sp_en   = 1'b1;
                sp_in   = STACK_BASE;
                state_d = ST_IDLE;
            end

            ST_IDLE: begin
                // A pending trap blocks the core even while memory is not ready.
                if (bus.trap_ret || bus.trap_req) begin
                    if (bus.mem_rdy) begin
                        if (frame_ok) begin
                            bus.trap_ack = 1'b1;
                            left_d       = LAST_BEAT;
                            state_d      = bus.trap_ret ? ST_RESTORE : ST_SAVE;
                        end else begin
                            bus.trap_err = 1'b1;
                        end
                    end
                end else if (bus.core_req) begin
                    case (op)
                        OP_PUSH, OP_POP: begin
                            if (bus.mem_rdy) begin
                                if (core_ok) begin
                                    bus.core_gnt = 1'b1;
                                    sp_en        = 1'b1;
                                    sp_in        = core_next;
                                    bus.mem_we   = (op == OP_PUSH);
                                    bus.mem_re   = (op == OP_POP);
                                    bus.mem_addr = (op == OP_PUSH) ? core_next : sp_q;
                                end else begin
                                    bus.core_err = 1'b1;
                                end
                            end
                        end
                        OP_ADJ: begin
                            if (core_ok) begin
                                bus.core_gnt = 1'b1;
                                sp_en        = 1'b1;
                                sp_in        = core_next;
                            end else begin
                                bus.core_err = 1'b1;
                            end
                        end
                        default: bus.core_gnt = 1'b1;
                    endcase
                end
            end

            ST_SAVE: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = sp_q - STEP;
                bus.mem_idx  = LAST_BEAT - left_q;
                if (bus.mem_rdy) begin
                    sp_en = 1'b1;
                    sp_in = sp_q - STEP;
                    if (left_q == '0) begin
                        bus.trap_done = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        left_d = left_q - 1'b1;
                    end
                end
            end

            ST_RESTORE: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = sp_q;
                bus.mem_idx  = left_q;
                if (bus.mem_rdy) begin
                    sp_en = 1'b1;
                    sp_in = sp_q + STEP;
                    if (left_q == '0) begin
                        bus.trap_done = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        left_d = left_q - 1'b1;
                    end
                end
            end

            default: state_d = ST_INIT;
        endcase

        if (!rstn) begin
            sp_en         = 1'b0;
            sp_in         = '0;
            bus.core_gnt  = 1'b0;
            bus.core_err  = 1'b0;
            bus.trap_ack  = 1'b0;
            bus.trap_done = 1'b0;
            bus.trap_err  = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_re    = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_idx   = '0;
        end
    end

endmodule
